// File: rtl/bcd_timer_ctrl.sv
// MM:SS BCD up/down timer with tick prescaler, speed levels, minute adjust and lap capture.
// Q drives the 7-segment display mux directly.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | loaded with the start value, waiting for START
// RUN   | counting one BCD step per prescaler period
// PAUSE | count frozen, partial prescaler period kept
// DONE  | target reached, Q held until CLEAR or RESET
module bcd_timer_ctrl #(
   parameter int          TICK_DIV     = 8,
   parameter logic [15:0] LOW_LIMIT    = 16'h1020,
   parameter logic [15:0] HIGH_LIMIT   = 16'h4030,
   parameter int          MIN_TENS_MAX = 5
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        START,
   input  logic        REVERSE,
   input  logic        CLEAR,
   input  logic        SPEED_UP,
   input  logic        SPEED_DOWN,
   input  logic        ADD,
   input  logic        SUBTRACT,
   input  logic        LAP,
   output logic [15:0] Q,
   output logic [15:0] LAP_Q,
   output logic        RUNNING,
   output logic        DONE
);

   localparam int         PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   lap_reg_q, lap_reg_d;
   logic          dir_q, dir_d;
   logic [1:0]    spd_q, spd_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] period_m1;
   logic [15:0]   target, cnt_step, cnt_adj;
   logic          tick, spd_chg, adj_ok;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
            else begin
               r[11:8]  = 4'd0;
               r[15:12] = (v[15:12] == MT_MAX) ? 4'd0 : v[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
            else begin
               r[11:8]  = 4'd9;
               r[15:12] = (v[15:12] == 4'd0) ? MT_MAX : v[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   // Direction is latched from REVERSE whenever not running, so target follows it live in IDLE.
   always_comb begin
      dir_d     = (state_q == S_RUN) ? dir_q : REVERSE;
      target    = dir_d ? LOW_LIMIT : HIGH_LIMIT;
      cnt_step  = dir_d ? bcd_dec(cnt_q) : bcd_inc(cnt_q);
      period_m1 = PW'((TICK_DIV >> spd_q) - 1);
      tick      = (state_q == S_RUN) && (presc_q == period_m1);
   end

   always_comb begin
      spd_d   = spd_q;
      spd_chg = 1'b0;
      if (SPEED_UP && !SPEED_DOWN && spd_q != 2'd3) begin
         spd_d   = spd_q + 2'd1;
         spd_chg = 1'b1;
      end else if (SPEED_DOWN && !SPEED_UP && spd_q != 2'd0) begin
         spd_d   = spd_q - 2'd1;
         spd_chg = 1'b1;
      end
   end

   // Minute adjust; a result outside the limits or past 00/MIN_TENS_MAX9 is dropped.
   always_comb begin
      cnt_adj = cnt_q;
      adj_ok  = 1'b0;
      if ((ADD ^ SUBTRACT) && (state_q == S_IDLE || state_q == S_PAUSE)) begin
         if (ADD) begin
            if (cnt_q[11:8] != 4'd9) begin
               cnt_adj[11:8] = cnt_q[11:8] + 4'd1;
               adj_ok        = 1'b1;
            end else if (cnt_q[15:12] != MT_MAX) begin
               cnt_adj[11:8]  = 4'd0;
               cnt_adj[15:12] = cnt_q[15:12] + 4'd1;
               adj_ok         = 1'b1;
            end
         end else begin
            if (cnt_q[11:8] != 4'd0) begin
               cnt_adj[11:8] = cnt_q[11:8] - 4'd1;
               adj_ok        = 1'b1;
            end else if (cnt_q[15:12] != 4'd0) begin
               cnt_adj[11:8]  = 4'd9;
               cnt_adj[15:12] = cnt_q[15:12] - 4'd1;
               adj_ok         = 1'b1;
            end
         end
         if (cnt_adj > HIGH_LIMIT || cnt_adj < LOW_LIMIT) adj_ok = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      presc_d   = presc_q;
      lap_reg_d = LAP ? cnt_q : lap_reg_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = (cnt_q == target) ? S_DONE : S_RUN;
               presc_d = '0;
            end
         end
         S_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) cnt_d = cnt_step;
            if (tick && cnt_step == target) state_d = S_DONE;
            else if (!START)                state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (START) state_d = S_RUN;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (adj_ok)  cnt_d   = cnt_adj;
      if (spd_chg) presc_d = '0;
      if (CLEAR) begin
         cnt_d   = dir_d ? HIGH_LIMIT : LOW_LIMIT;
         presc_d = '0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= LOW_LIMIT;
         lap_reg_q <= '0;
         dir_q     <= 1'b0;
         spd_q     <= 2'd0;
         presc_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lap_reg_q <= lap_reg_d;
         dir_q     <= dir_d;
         spd_q     <= spd_d;
         presc_q   <= presc_d;
      end
   end

   assign Q       = cnt_q;
   assign LAP_Q   = lap_reg_q;
   assign RUNNING = (state_q == S_RUN);
   assign DONE    = (state_q == S_DONE);

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Parametrised MM:SS BCD up/down timer. Successor to the fixed 4-digit stopwatch: configurable start/stop limits, internal tick prescaler with 4 speed levels, and ±1-minute adjust while stopped. It also adds a lap capture register and an explicit run/pause/done FSM with status outputs. Sits between the board clock and the 7-segment display driver; Q feeds the display mux directly.

Parameters:
TICK_DIV, 8, clk cycles per count step at speed 0; must be a multiple of 8
LOW_LIMIT, 16'h1020, BCD MM:SS lower bound; start value for up-count, stop value for down-count
HIGH_LIMIT, 16'h4030, BCD MM:SS upper bound; start value for down-count, stop value for up-count
MIN_TENS_MAX, 5, maximum minute-tens digit; LOW_LIMIT < HIGH_LIMIT, both valid BCD within range

Ports:
clk  in  1  single clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  level; 1 = run, 0 = pause
REVERSE  in  1  level; 1 = count down; sampled only when state != RUN
CLEAR  in  1  pulse; reload start value for the current direction
SPEED_UP  in  1  pulse; speed level +1, saturates at 3
SPEED_DOWN  in  1  pulse; speed level -1, saturates at 0
ADD  in  1  pulse; +1 minute (IDLE/PAUSE only)
SUBTRACT  in  1  pulse; -1 minute (IDLE/PAUSE only)
LAP  in  1  pulse; capture Q into LAP_Q
Q  out  16  {min tens, min units, sec tens, sec units} BCD
LAP_Q  out  16  last captured Q
RUNNING  out  1  1 in RUN
DONE  out  1  1 in DONE

Behaviour:
- Reset (sync): Q=LOW_LIMIT, LAP_Q=0, dir=0, spd=0, prescaler=0, state=IDLE, RUNNING=0, DONE=0.
- Priority per cycle: RESET > CLEAR > ADD/SUBTRACT > tick step.
- dir register: loads REVERSE every cycle the state is not RUN; frozen in RUN. target = dir ? LOW_LIMIT : HIGH_LIMIT.
- CLEAR: Q = dir ? HIGH_LIMIT : LOW_LIMIT (dir as updated the same cycle), prescaler=0, state=IDLE, DONE=0. spd and LAP_Q unchanged.
- FSM:
  IDLE: START=1 -> RUN, or DONE if Q==target.
  RUN: START=0 -> PAUSE; tick whose stepped Q==target -> DONE (Q takes the target value).
  PAUSE: START=1 -> RUN.
  DONE: holds Q; leaves only on CLEAR/RESET; START ignored.
- Prescaler: period P = TICK_DIV >> spd (defaults: 8, 4, 2, 1).
  - Counts only in RUN; holds its value in PAUSE so the partial period is kept.
  - Cleared on IDLE->RUN, CLEAR, RESET, and any accepted speed change.
  - tick = (prescaler == P-1) in RUN; prescaler then wraps to 0.
  - Q updates on the edge where tick is asserted, so the first step is P cycles after entering RUN from IDLE.
- Step: BCD ripple. Sec units 0-9, sec tens 0-5, min units 0-9, min tens 0-MIN_TENS_MAX.
  - Up: 9->0 carries into the next digit; sec tens 5->0 carries into minutes.
  - Down: mirror with borrows, e.g. 4000 -> 3959.
  - No wrap is reachable, because the target stops the count first.
- SPEED_UP and SPEED_DOWN in the same cycle: no change. A pulse at saturation is ignored and does not clear the prescaler.
- ADD/SUBTRACT: accepted only in IDLE or PAUSE, and only one of the two asserted.
  - Adjusts minutes by ±1 with BCD carry/borrow between min units and min tens; seconds are unchanged.
  - Ignored if the result would be > HIGH_LIMIT or < LOW_LIMIT.
  - Ignored in RUN and in DONE.
- LAP: in any state, LAP_Q <= Q value before this cycle's update.
- RESET mid-RUN: all reset values on the next edge, regardless of other inputs.

Test Plan:
1. RESET, then START=1 held (defaults) -> Q=1020; Q=1021 after 8 cycles, 1022 after 16; RUNNING=1.
2. SPEED_UP x3 (spd=3, P=1), START up-count from 1020 -> transitions 1059->1100 and 1959->2000 seen; after 1810 ticks Q=4030, DONE=1, RUNNING=0; Q holds while START stays 1.
3. REVERSE=1 in IDLE, CLEAR -> Q=4030. START at spd=3 -> 4000->3959 seen; after 1810 ticks Q=1020, DONE=1. CLEAR -> DONE=0, Q=4030.
4. Pause/direction: spd=0, drop START when prescaler=5 -> Q frozen, PAUSE; re-raise START -> step after exactly 3 cycles. REVERSE toggled in RUN -> count direction unchanged.
5. Adjust:
  - IDLE Q=1020: SUBTRACT ignored; ADD -> 1120.
  - Q=3930: ADD -> 4030, then a further ADD is ignored.
  - ADD+SUBTRACT together -> ignored.
  - ADD in RUN -> ignored.
6. Speed/lap/reset:
  - SPEED_UP x5 -> spd saturates at 3 (P=1).
  - LAP in RUN at Q=1025 -> LAP_Q=1025 while Q keeps counting.
  - RESET mid-RUN -> next cycle Q=1020, LAP_Q=0, spd=0, IDLE.
